// File: rtl/cla_pkg.sv
// -----------------------------------------------------------------------------
// cla_pkg
// Shared types and default geometry for the cacheline burst adaptor.
//   cla_state_t   : adaptor FSM states
//   CLA_LINE_W    : default cache line width (bits)
//   CLA_BEAT_W    : default burst beat width (bits)
//   CLA_BEATS     : beats per line
//   CLA_OFFSET_W  : byte-offset bits inside one line
// -----------------------------------------------------------------------------
package cla_pkg;

    localparam int CLA_LINE_W   = 256;
    localparam int CLA_BEAT_W   = 64;
    localparam int CLA_BEATS    = CLA_LINE_W / CLA_BEAT_W;
    localparam int CLA_OFFSET_W = $clog2(CLA_LINE_W / 8);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WR_BURST = 2'd1,
        ST_RD_BURST = 2'd2,
        ST_DONE     = 2'd3
    } cla_state_t;

endpackage : cla_pkg

// File: rtl/cla_line_buffer.sv
// -----------------------------------------------------------------------------
// cla_line_buffer
// One cache-line register viewed as BEATS beats of BEAT_W bits.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset (clears the line)
//   load_en       : load the whole line from load_line (wins over beat write)
//   load_line     : full-line load data
//   beat_wr_en    : write beat_wdata into slot beat_wr_idx
//   beat_wr_idx   : beat slot to write
//   beat_wdata    : beat write data
//   beat_rd_idx   : beat slot presented on beat_rdata
//   beat_rdata    : selected beat (from the register, no input path)
//   line_data     : whole stored line; beat 0 is bits [BEAT_W-1:0]
// -----------------------------------------------------------------------------
module cla_line_buffer
    import cla_pkg::*;
#(
    parameter  int LINE_W = CLA_LINE_W,
    parameter  int BEAT_W = CLA_BEAT_W,
    localparam int BEATS  = LINE_W / BEAT_W,
    localparam int IDX_W  = $clog2(BEATS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_en,
    input  logic [LINE_W-1:0] load_line,
    input  logic              beat_wr_en,
    input  logic [IDX_W-1:0]  beat_wr_idx,
    input  logic [BEAT_W-1:0] beat_wdata,
    input  logic [IDX_W-1:0]  beat_rd_idx,
    output logic [BEAT_W-1:0] beat_rdata,
    output logic [LINE_W-1:0] line_data
);

    logic [BEATS-1:0][BEAT_W-1:0] line_r;

    // Line storage: full-line load takes priority over a single-beat write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_r <= '0;
        end else if (load_en) begin
            line_r <= load_line;
        end else if (beat_wr_en) begin
            line_r[beat_wr_idx] <= beat_wdata;
        end else begin
            line_r <= line_r;
        end
    end

    assign beat_rdata = line_r[beat_rd_idx];
    assign line_data  = line_r;

endmodule : cla_line_buffer

// File: rtl/cacheline_burst_adaptor.sv
// -----------------------------------------------------------------------------
// cacheline_burst_adaptor
// Serves whole-line pmem_read / pmem_write requests from a cache as fixed
// BEATS-long bursts on the narrow bmem bus, then pulses pmem_resp for one
// cycle. Write wins when both requests are raised together; the read is then
// picked up on the next IDLE sample. DONE never samples requests, so a request
// still held one cycle after pmem_resp is not served twice.
//
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   pmem_read/_write    : line requests, held by the cache until pmem_resp
//   pmem_address        : line address (offset bits ignored)
//   pmem_wdata          : write-back line
//   pmem_rdata          : last assembled read line
//   pmem_resp           : one-cycle completion pulse
//   bmem_read/_write    : burst request strobes (high for the whole burst)
//   bmem_address        : line-aligned burst address, 0 outside a burst
//   bmem_wdata          : current write beat
//   bmem_rdata          : current read beat
//   bmem_resp           : one beat transferred per high cycle
//
// Optional feature macro: CLA_LAST_LINE_BUF_EN
//   Adds a one-entry last-line buffer; a read hitting it completes at T+1
//   without any bmem traffic. Absent by default.
//
// Every output is driven straight from a register, so no pmem_* input reaches
// a bmem_* output combinationally.
// -----------------------------------------------------------------------------
module cacheline_burst_adaptor
    import cla_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LINE_W = CLA_LINE_W,
    parameter int BEAT_W = CLA_BEAT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pmem_read,
    input  logic              pmem_write,
    input  logic [ADDR_W-1:0] pmem_address,
    input  logic [LINE_W-1:0] pmem_wdata,
    output logic [LINE_W-1:0] pmem_rdata,
    output logic              pmem_resp,
    output logic              bmem_read,
    output logic              bmem_write,
    output logic [ADDR_W-1:0] bmem_address,
    output logic [BEAT_W-1:0] bmem_wdata,
    input  logic [BEAT_W-1:0] bmem_rdata,
    input  logic              bmem_resp
);

    localparam int BEATS    = LINE_W / BEAT_W;
    localparam int OFFSET_W = $clog2(LINE_W / 8);
    localparam int CNT_W    = $clog2(BEATS);
    localparam int TAG_W    = ADDR_W - OFFSET_W;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    cla_state_t        state_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              pmem_resp_r;
    logic              bmem_read_r;
    logic              bmem_write_r;
    logic [ADDR_W-1:0] bmem_address_r;
    logic [BEAT_W-1:0] bmem_wdata_r;

    logic [TAG_W-1:0]    tag_s;
    logic [ADDR_W-1:0]   aligned_s;
    logic [CNT_W-1:0]    next_idx_s;
    logic                accept_wr_s;
    logic                accept_rd_s;
    logic                llb_hit_s;
    logic [LINE_W-1:0]   llb_line_s;
    logic                rd_beat_s;
    logic                rd_last_strobe_s;
    logic [BEAT_W-1:0]   wr_next_beat_s;
    logic [BEAT_W-1:0]   rd_beat_unused_s;
    logic [LINE_W-1:0]   wr_line_unused_s;
    logic [OFFSET_W-1:0] addr_offset_unused_s;

    assign tag_s                = pmem_address[ADDR_W-1:OFFSET_W];
    assign aligned_s            = {tag_s, {OFFSET_W{1'b0}}};
    assign addr_offset_unused_s = pmem_address[OFFSET_W-1:0];
    assign next_idx_s           = cnt_r + CNT_W'(1'b1);

    // Request decode only matters in IDLE; write has priority over read.
    assign accept_wr_s      = (state_r == ST_IDLE) && pmem_write;
    assign accept_rd_s      = (state_r == ST_IDLE) && !pmem_write && pmem_read;
    assign rd_beat_s        = (state_r == ST_RD_BURST) && bmem_resp;
    assign rd_last_strobe_s = rd_beat_s && (cnt_r == LAST_BEAT);

    // Write-back line captured at acceptance; the next beat is read ahead so
    // bmem_wdata can be a register.
    cla_line_buffer #(
        .LINE_W (LINE_W),
        .BEAT_W (BEAT_W)
    ) u_wr_line (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_en     (accept_wr_s),
        .load_line   (pmem_wdata),
        .beat_wr_en  (1'b0),
        .beat_wr_idx (cnt_r),
        .beat_wdata  ({BEAT_W{1'b0}}),
        .beat_rd_idx (next_idx_s),
        .beat_rdata  (wr_next_beat_s),
        .line_data   (wr_line_unused_s)
    );

    // Read line assembled beat by beat; also loaded whole on a last-line hit.
    cla_line_buffer #(
        .LINE_W (LINE_W),
        .BEAT_W (BEAT_W)
    ) u_rd_line (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_en     (accept_rd_s && llb_hit_s),
        .load_line   (llb_line_s),
        .beat_wr_en  (rd_beat_s),
        .beat_wr_idx (cnt_r),
        .beat_wdata  (bmem_rdata),
        .beat_rd_idx (cnt_r),
        .beat_rdata  (rd_beat_unused_s),
        .line_data   (pmem_rdata)
    );

`ifdef CLA_LAST_LINE_BUF_EN
    logic              llb_valid_r;
    logic [TAG_W-1:0]  llb_tag_r;
    logic [LINE_W-1:0] llb_line_r;

    assign llb_hit_s  = llb_valid_r && (llb_tag_r == tag_s);
    assign llb_line_s = llb_line_r;

    // Last-line buffer: refreshed on write acceptance and on the final read
    // beat (the final beat is merged in directly since it is not stored yet).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            llb_valid_r <= 1'b0;
            llb_tag_r   <= '0;
            llb_line_r  <= '0;
        end else if (accept_wr_s) begin
            llb_valid_r <= 1'b1;
            llb_tag_r   <= tag_s;
            llb_line_r  <= pmem_wdata;
        end else if (rd_last_strobe_s) begin
            llb_valid_r <= 1'b1;
            llb_tag_r   <= bmem_address_r[ADDR_W-1:OFFSET_W];
            llb_line_r  <= {bmem_rdata, pmem_rdata[LINE_W-BEAT_W-1:0]};
        end else begin
            llb_valid_r <= llb_valid_r;
            llb_tag_r   <= llb_tag_r;
            llb_line_r  <= llb_line_r;
        end
    end
`else
    assign llb_hit_s  = 1'b0;
    assign llb_line_s = {LINE_W{1'b0}};
`endif

    // Adaptor FSM with registered bmem/pmem control outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= ST_IDLE;
            cnt_r          <= '0;
            pmem_resp_r    <= 1'b0;
            bmem_read_r    <= 1'b0;
            bmem_write_r   <= 1'b0;
            bmem_address_r <= '0;
            bmem_wdata_r   <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    cnt_r <= '0;
                    if (accept_wr_s) begin
                        state_r        <= ST_WR_BURST;
                        bmem_write_r   <= 1'b1;
                        bmem_address_r <= aligned_s;
                        bmem_wdata_r   <= pmem_wdata[BEAT_W-1:0];
                    end else if (accept_rd_s && llb_hit_s) begin
                        state_r     <= ST_DONE;
                        pmem_resp_r <= 1'b1;
                    end else if (accept_rd_s) begin
                        state_r        <= ST_RD_BURST;
                        bmem_read_r    <= 1'b1;
                        bmem_address_r <= aligned_s;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_WR_BURST: begin
                    if (bmem_resp && (cnt_r == LAST_BEAT)) begin
                        state_r        <= ST_DONE;
                        cnt_r          <= '0;
                        pmem_resp_r    <= 1'b1;
                        bmem_write_r   <= 1'b0;
                        bmem_address_r <= '0;
                        bmem_wdata_r   <= '0;
                    end else if (bmem_resp) begin
                        cnt_r        <= next_idx_s;
                        bmem_wdata_r <= wr_next_beat_s;
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                ST_RD_BURST: begin
                    if (rd_last_strobe_s) begin
                        state_r        <= ST_DONE;
                        cnt_r          <= '0;
                        pmem_resp_r    <= 1'b1;
                        bmem_read_r    <= 1'b0;
                        bmem_address_r <= '0;
                    end else if (bmem_resp) begin
                        cnt_r <= next_idx_s;
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                ST_DONE: begin
                    state_r     <= ST_IDLE;
                    pmem_resp_r <= 1'b0;
                end
                default: begin
                    state_r        <= ST_IDLE;
                    cnt_r          <= '0;
                    pmem_resp_r    <= 1'b0;
                    bmem_read_r    <= 1'b0;
                    bmem_write_r   <= 1'b0;
                    bmem_address_r <= '0;
                    bmem_wdata_r   <= '0;
                end
            endcase
        end
    end

    assign pmem_resp    = pmem_resp_r;
    assign bmem_read    = bmem_read_r;
    assign bmem_write   = bmem_write_r;
    assign bmem_address = bmem_address_r;
    assign bmem_wdata   = bmem_wdata_r;

endmodule : cacheline_burst_adaptor

// File: tb/tb_cacheline_burst_adaptor.sv
// -----------------------------------------------------------------------------
// tb_cacheline_burst_adaptor
// Bench acting as both the cache (pmem side) and the burst memory (bmem side).
// Expected data comes from a line-level reference memory and expected timing
// from the rule "bursts start at T+1, pmem_resp one cycle after the last
// strobe" (or T+1 on a last-line-buffer hit when that feature is built in).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cacheline_burst_adaptor;

    localparam int ADDR_W = 32;
    localparam int LINE_W = 256;
    localparam int BEAT_W = 64;
    localparam int BEATS  = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              pmem_read = 1'b0;
    logic              pmem_write = 1'b0;
    logic [ADDR_W-1:0] pmem_address = '0;
    logic [LINE_W-1:0] pmem_wdata = '0;
    logic [LINE_W-1:0] pmem_rdata;
    logic              pmem_resp;
    logic              bmem_read;
    logic              bmem_write;
    logic [ADDR_W-1:0] bmem_address;
    logic [BEAT_W-1:0] bmem_wdata;
    logic [BEAT_W-1:0] bmem_rdata = '0;
    logic              bmem_resp = 1'b0;

    always #5 clk = ~clk;

    cacheline_burst_adaptor #(
        .ADDR_W (ADDR_W),
        .LINE_W (LINE_W),
        .BEAT_W (BEAT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp),
        .bmem_read    (bmem_read),
        .bmem_write   (bmem_write),
        .bmem_address (bmem_address),
        .bmem_wdata   (bmem_wdata),
        .bmem_rdata   (bmem_rdata),
        .bmem_resp    (bmem_resp)
    );

    int tests_run = 0;
    int tests_failed = 0;

    // mem: what the burst memory holds; ref_mem: what it should hold.
    logic [LINE_W-1:0] mem     [logic [31:0]];
    logic [LINE_W-1:0] ref_mem [logic [31:0]];
    bit                ref_llb_valid = 1'b0;
    logic [31:0]       ref_llb_tag = '0;

    function automatic logic [31:0] align(input logic [31:0] a);
        return {a[31:5], 5'b0};
    endfunction

    task automatic ensure_line(input logic [31:0] a);
        logic [LINE_W-1:0] v;
        if (!ref_mem.exists(a)) begin
            for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
            ref_mem[a] = v;
            mem[a]     = v;
        end
    endtask

    function automatic bit model_hit(input logic [31:0] a);
`ifdef CLA_LAST_LINE_BUF_EN
        return ref_llb_valid && (ref_llb_tag == a);
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_commit(input bit wr, input logic [31:0] a, input logic [LINE_W-1:0] wl);
        if (wr) ref_mem[a] = wl;
        ref_llb_valid = 1'b1;
        ref_llb_tag   = a;
    endtask

    // Issue one line request and act as the burst memory until pmem_resp.
    // k counts cycles after the acceptance edge (k=1 is cycle T+1).
    task automatic run_op(input bit wr, input bit keep_read, input logic [31:0] addr,
                          input logic [LINE_W-1:0] wl, input int min_gap, input int max_gap,
                          output logic [LINE_W-1:0] rl, output logic [LINE_W-1:0] wseen,
                          output int resp_k, output int last_k, output int first_busy_k,
                          output int nstrobes, output int bad_addr, output bit saw_rd, output bit saw_wr);
        int gap;
        logic [31:0] a;
        logic [LINE_W-1:0] tmp;
        a = align(addr);
        rl = '0; wseen = '0; resp_k = -1; last_k = -1; first_busy_k = -1;
        nstrobes = 0; bad_addr = 0; saw_rd = 1'b0; saw_wr = 1'b0;
        gap = $urandom_range(max_gap, min_gap);
        @(negedge clk);
        pmem_address = addr;
        pmem_wdata   = wl;
        if (wr) begin
            pmem_write = 1'b1;
            if (keep_read) pmem_read = 1'b1;
        end else begin
            pmem_read = 1'b1;
        end
        for (int k = 1; k <= 200 && resp_k < 0; k++) begin
            @(negedge clk);
            bmem_resp = 1'b0;
            if (bmem_read)  saw_rd = 1'b1;
            if (bmem_write) saw_wr = 1'b1;
            if (pmem_resp) begin
                resp_k = k;
                rl = pmem_rdata;
                if (wr) pmem_write = 1'b0;
                else    pmem_read  = 1'b0;
            end else if (bmem_read || bmem_write) begin
                if (first_busy_k < 0) first_busy_k = k;
                if (gap > 0) begin
                    gap--;
                end else begin
                    if (bmem_address !== a) bad_addr++;
                    if (nstrobes < BEATS) begin
                        if (bmem_write) begin
                            wseen[nstrobes*BEAT_W +: BEAT_W] = bmem_wdata;
                        end else begin
                            tmp = mem.exists(bmem_address) ? mem[bmem_address] : '0;
                            bmem_rdata = tmp[nstrobes*BEAT_W +: BEAT_W];
                        end
                    end
                    bmem_resp = 1'b1;
                    nstrobes++;
                    last_k = k;
                    gap = $urandom_range(max_gap, min_gap);
                end
            end
        end
        bmem_resp = 1'b0;
        if (wr) mem[a] = wseen;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ref_llb_valid = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++; if (pmem_resp !== 1'b0) begin tests_failed++; $display("FAIL reset_pmem_resp got=%b exp=0", pmem_resp); end
        tests_run++; if (bmem_read !== 1'b0) begin tests_failed++; $display("FAIL reset_bmem_read got=%b exp=0", bmem_read); end
        tests_run++; if (bmem_write !== 1'b0) begin tests_failed++; $display("FAIL reset_bmem_write got=%b exp=0", bmem_write); end
        tests_run++; if (bmem_address !== 32'h0) begin tests_failed++; $display("FAIL reset_bmem_address got=%h exp=0", bmem_address); end
        tests_run++; if (bmem_wdata !== 64'h0) begin tests_failed++; $display("FAIL reset_bmem_wdata got=%h exp=0", bmem_wdata); end
        tests_run++; if (pmem_rdata !== 256'h0) begin tests_failed++; $display("FAIL reset_pmem_rdata got=%h exp=0", pmem_rdata); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++; if ({bmem_read, bmem_write, pmem_resp} !== 3'b000) begin tests_failed++; $display("FAIL idle_after_reset got=%b exp=000", {bmem_read, bmem_write, pmem_resp}); end
    endtask

    task automatic test_read_basic();
        logic [LINE_W-1:0] rl, ws, exp_line;
        int rk, lk, fb, ns, ba;
        bit sr, sw;
        exp_line = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                    64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        mem[32'h1220] = exp_line;
        ref_mem[32'h1220] = exp_line;
        run_op(1'b0, 1'b0, 32'h0000_1234, '0, 0, 0, rl, ws, rk, lk, fb, ns, ba, sr, sw);
        tests_run++; if (ba !== 0) begin tests_failed++; $display("FAIL rd_basic_addr bad_beats=%0d exp=0 (addr 0x1220)", ba); end
        tests_run++; if (rl !== ref_mem[32'h1220]) begin tests_failed++; $display("FAIL rd_basic_data got=%h exp=%h", rl, ref_mem[32'h1220]); end
        tests_run++; if (rk !== 5) begin tests_failed++; $display("FAIL rd_basic_latency got=T+%0d exp=T+5", rk); end
        tests_run++; if (ns !== BEATS || sw !== 1'b0) begin tests_failed++; $display("FAIL rd_basic_beats got=%0d wr=%b exp=4 wr=0", ns, sw); end
        model_commit(1'b0, 32'h1220, '0);
    endtask

    task automatic test_write_gaps();
        logic [LINE_W-1:0] rl, ws, wl;
        int rk, lk, fb, ns, ba;
        bit sr, sw;
        wl = {32{8'hAA}};
        wl[BEAT_W-1:0] = 64'hAAAA_AAAA_AAAA_0001;
        wl[3*BEAT_W +: BEAT_W] = 64'hAAAA_AAAA_AAAA_0004;
        run_op(1'b1, 1'b0, 32'h0000_0100, wl, 1, 1, rl, ws, rk, lk, fb, ns, ba, sr, sw);
        tests_run++; if (ws !== wl) begin tests_failed++; $display("FAIL wr_gap_beats got=%h exp=%h", ws, wl); end
        tests_run++; if (ns !== BEATS || ba !== 0 || sr !== 1'b0) begin tests_failed++; $display("FAIL wr_gap_burst got=%0d bad=%0d rd=%b exp=4 0 0", ns, ba, sr); end
        tests_run++; if (rk !== 9 || rk !== lk + 1) begin tests_failed++; $display("FAIL wr_gap_latency got=%0d last=%0d exp=9", rk, lk); end
        @(negedge clk);
        tests_run++; if ({bmem_write, pmem_resp} !== 2'b00) begin tests_failed++; $display("FAIL wr_gap_after got=%b exp=00", {bmem_write, pmem_resp}); end
        model_commit(1'b1, 32'h100, wl);
    endtask

    task automatic test_back_to_back();
        logic [LINE_W-1:0] rl, ws, wl, rl2, ws2;
        int rk, lk, fb, ns, ba, rk2, lk2, fb2, ns2, ba2;
        bit sr, sw, sr2, sw2;
        for (int i = 0; i < 8; i++) wl[i*32 +: 32] = $urandom;
        ensure_line(32'h300);
        run_op(1'b1, 1'b0, 32'h200, wl, 0, 0, rl, ws, rk, lk, fb, ns, ba, sr, sw);
        model_commit(1'b1, 32'h200, wl);
        run_op(1'b0, 1'b0, 32'h300, '0, 0, 0, rl2, ws2, rk2, lk2, fb2, ns2, ba2, sr2, sw2);
        tests_run++; if (ws !== wl || ns !== BEATS || sr !== 1'b0) begin tests_failed++; $display("FAIL b2b_write got=%0d beats rd=%b exp=4 beats rd=0", ns, sr); end
        tests_run++; if (fb2 !== 1) begin tests_failed++; $display("FAIL b2b_read_start got=D+%0d exp=D+2", fb2 + 1); end
        tests_run++; if (ns2 !== BEATS || sw2 !== 1'b0 || rk2 !== lk2 + 1) begin tests_failed++; $display("FAIL b2b_read_burst got=%0d wr=%b resp=%0d exp=4 0 %0d", ns2, sw2, rk2, lk2 + 1); end
        tests_run++; if (rl2 !== ref_mem[32'h300]) begin tests_failed++; $display("FAIL b2b_read_data got=%h exp=%h", rl2, ref_mem[32'h300]); end
        model_commit(1'b0, 32'h300, '0);
    endtask

    task automatic test_reset_mid_burst();
        logic [LINE_W-1:0] rl, ws, tmp;
        int rk, lk, fb, ns, ba, n;
        bit sr, sw;
        ensure_line(32'h500);
        @(negedge clk);
        pmem_address = 32'h500;
        pmem_read = 1'b1;
        n = 0;
        for (int k = 0; k < 20 && n < 2; k++) begin
            @(negedge clk);
            bmem_resp = 1'b0;
            if (bmem_read) begin
                tmp = mem[32'h500];
                bmem_rdata = tmp[n*BEAT_W +: BEAT_W];
                bmem_resp = 1'b1;
                n++;
            end
        end
        @(negedge clk);
        bmem_resp = 1'b0;
        pmem_read = 1'b0;
        rst_n = 1'b0;
        ref_llb_valid = 1'b0;
        #1;
        tests_run++; if (n !== 2) begin tests_failed++; $display("FAIL rst_mid_setup got=%0d beats exp=2", n); end
        tests_run++; if ({pmem_resp, bmem_read, bmem_write} !== 3'b000) begin tests_failed++; $display("FAIL rst_mid_ctrl got=%b exp=000", {pmem_resp, bmem_read, bmem_write}); end
        tests_run++; if (bmem_address !== 32'h0 || bmem_wdata !== 64'h0 || pmem_rdata !== 256'h0) begin tests_failed++; $display("FAIL rst_mid_data got=%h/%h/%h exp=0", bmem_address, bmem_wdata, pmem_rdata); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            tests_run++; if (pmem_resp !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_noresp got=%b exp=0", pmem_resp); end
        end
        run_op(1'b0, 1'b0, 32'h510, '0, 0, 0, rl, ws, rk, lk, fb, ns, ba, sr, sw);
        tests_run++; if (rl !== ref_mem[32'h500]) begin tests_failed++; $display("FAIL rst_mid_refetch got=%h exp=%h", rl, ref_mem[32'h500]); end
        tests_run++; if (rk !== 5 || ns !== BEATS || ba !== 0) begin tests_failed++; $display("FAIL rst_mid_refetch_timing got=%0d beats=%0d bad=%0d exp=5 4 0", rk, ns, ba); end
        model_commit(1'b0, 32'h500, '0);
    endtask

    task automatic test_spurious_and_both();
        logic [LINE_W-1:0] rl, ws, wl, rl2, ws2;
        int rk, lk, fb, ns, ba, rk2, lk2, fb2, ns2, ba2;
        bit sr, sw, sr2, sw2, hit;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            bmem_resp = 1'b1;
            @(negedge clk);
            bmem_resp = 1'b0;
            tests_run++; if ({bmem_read, bmem_write, pmem_resp} !== 3'b000) begin tests_failed++; $display("FAIL spurious_idle got=%b exp=000", {bmem_read, bmem_write, pmem_resp}); end
        end
        for (int i = 0; i < 8; i++) wl[i*32 +: 32] = $urandom;
        ensure_line(32'h600);
        run_op(1'b1, 1'b1, 32'h600, wl, 0, 2, rl, ws, rk, lk, fb, ns, ba, sr, sw);
        model_commit(1'b1, 32'h600, wl);
        tests_run++; if (sr !== 1'b0 || ws !== wl || ns !== BEATS) begin tests_failed++; $display("FAIL both_write_first got rd=%b beats=%0d exp rd=0 beats=4", sr, ns); end
        hit = model_hit(32'h600);
        run_op(1'b0, 1'b0, 32'h600, '0, 0, 2, rl2, ws2, rk2, lk2, fb2, ns2, ba2, sr2, sw2);
        tests_run++; if (rl2 !== wl) begin tests_failed++; $display("FAIL both_read_data got=%h exp=%h", rl2, wl); end
        tests_run++; if (ns2 !== (hit ? 0 : BEATS) || rk2 !== (hit ? 1 : lk2 + 1)) begin tests_failed++; $display("FAIL both_read_timing got beats=%0d resp=%0d hit=%b", ns2, rk2, hit); end
        model_commit(1'b0, 32'h600, '0);
    endtask

    task automatic test_repeat_read();
        logic [LINE_W-1:0] rl, ws;
        int rk, lk, fb, ns, ba;
        bit sr, sw, hit;
        logic [31:0] addrs [3];
        addrs[0] = 32'h400; addrs[1] = 32'h400; addrs[2] = 32'h420;
        for (int i = 0; i < 3; i++) begin
            ensure_line(addrs[i]);
            hit = model_hit(addrs[i]);
            run_op(1'b0, 1'b0, addrs[i], '0, 0, 0, rl, ws, rk, lk, fb, ns, ba, sr, sw);
            tests_run++; if (rl !== ref_mem[addrs[i]]) begin tests_failed++; $display("FAIL rpt_read_data[%0d] got=%h exp=%h", i, rl, ref_mem[addrs[i]]); end
            tests_run++; if (rk !== (hit ? 1 : 5) || sr !== !hit) begin tests_failed++; $display("FAIL rpt_read_timing[%0d] got=T+%0d bmem_read=%b exp=T+%0d bmem_read=%b", i, rk, sr, hit ? 1 : 5, !hit); end
            model_commit(1'b0, addrs[i], '0);
        end
    endtask

    task automatic test_random();
        logic [LINE_W-1:0] rl, ws, wl;
        int rk, lk, fb, ns, ba;
        bit sr, sw, hit, wr;
        logic [31:0] addr, a;
        for (int t = 0; t < 24; t++) begin
            wr = 1'(($urandom & 32'd1));
            addr = 32'h800 + 32'($urandom_range(3, 0)) * 32'h20 + 32'($urandom_range(31, 0));
            a = align(addr);
            ensure_line(a);
            for (int i = 0; i < 8; i++) wl[i*32 +: 32] = $urandom;
            hit = wr ? 1'b0 : model_hit(a);
            run_op(wr, 1'b0, addr, wl, 0, 3, rl, ws, rk, lk, fb, ns, ba, sr, sw);
            if (wr) begin
                tests_run++; if (ws !== wl || sr !== 1'b0) begin tests_failed++; $display("FAIL rnd_write[%0d] got=%h exp=%h", t, ws, wl); end
            end else begin
                tests_run++; if (rl !== ref_mem[a] || sw !== 1'b0) begin tests_failed++; $display("FAIL rnd_read[%0d] got=%h exp=%h", t, rl, ref_mem[a]); end
            end
            tests_run++;
            if (hit ? (rk !== 1 || ns !== 0)
                    : (ns !== BEATS || rk !== lk + 1 || fb !== 1 || ba !== 0)) begin
                tests_failed++;
                $display("FAIL rnd_timing[%0d] got resp=%0d last=%0d start=%0d beats=%0d bad=%0d hit=%b", t, rk, lk, fb, ns, ba, hit);
            end
            model_commit(wr, a, wl);
            repeat ($urandom_range(2, 0)) @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_read_basic();
        test_write_gaps();
        test_back_to_back();
        test_reset_mid_burst();
        test_spurious_and_both();
        test_repeat_read();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_cacheline_burst_adaptor

// File: doc/cacheline_burst_adaptor.md
# cacheline_burst_adaptor

Responder for the cache's physical-memory port. It accepts whole-line `pmem_read`/`pmem_write` requests from a cache controller and serves each one as a fixed-length beat burst on the narrow burst-memory bus. It returns a single-cycle `pmem_resp` when the transfer completes. It sits between each cache (or the cache arbiter) and main memory.

## Interface
Parameters:
- `ADDR_W`, 32, byte-address width.
- `LINE_W`, 256, cache line width in bits.
- `BEAT_W`, 64, burst beat width in bits. `BEATS = LINE_W/BEAT_W` must be a power of two and at least 2.

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `pmem_read`  in  1  line read request; held high by the cache until `pmem_resp`.
- `pmem_write`  in  1  line write-back request; held high until `pmem_resp`.
- `pmem_address`  in  ADDR_W  line address; low log2(LINE_W/8) bits ignored.
- `pmem_wdata`  in  LINE_W  write-back line.
- `pmem_rdata`  out  LINE_W  read line; valid while `pmem_resp`=1.
- `pmem_resp`  out  1  one-cycle completion pulse.
- `bmem_read`  out  1  burst read request.
- `bmem_write`  out  1  burst write request.
- `bmem_address`  out  ADDR_W  line-aligned burst address.
- `bmem_wdata`  out  BEAT_W  current write beat.
- `bmem_rdata`  in  BEAT_W  current read beat.
- `bmem_resp`  in  1  beat strobe; one beat per high cycle.

## Operation
- States: IDLE, WR_BURST, RD_BURST, DONE.
- IDLE:
  - `pmem_write`=1: capture the aligned address and `pmem_wdata`, clear the beat counter, go to WR_BURST.
  - Else `pmem_read`=1: capture the aligned address, clear the beat counter, go to RD_BURST.
  - If both are high, write wins. The read is then served by the next IDLE sample.
- WR_BURST:
  - `bmem_write`=1.
  - `bmem_wdata` = captured line beat[counter], beat 0 = bits [BEAT_W-1:0].
  - Each `bmem_resp`=1 cycle advances the counter. The strobe on beat BEATS-1 moves to DONE.
- RD_BURST:
  - `bmem_read`=1.
  - On each `bmem_resp`=1, store `bmem_rdata` into line slot [counter] and increment the counter. Beat BEATS-1 moves to DONE.
- DONE:
  - `pmem_resp`=1; `pmem_rdata` = assembled line (or the last read line after a write).
  - Always returns to IDLE next cycle. Requests are not sampled in DONE, so a request the cache holds for one extra cycle is never re-served.
- `bmem_resp` is ignored in IDLE and DONE.
- Beats need not be consecutive; the counter moves only on strobes.
- Counter width is log2(BEATS) and never wraps within a burst.
- `bmem_address` = captured address with offset bits forced to 0. It is stable for the whole burst and 0 in IDLE.

## Timing
- Reset (async assert, sync-safe deassert):
  - State IDLE, counter 0.
  - `pmem_resp`, `bmem_read`, `bmem_write` = 0.
  - `bmem_address`, `bmem_wdata`, `pmem_rdata` = 0.
- Reset mid-burst abandons the burst immediately. No `pmem_resp` is issued for it.
- Acceptance cycle T: the request is seen in IDLE.
- T+1: `bmem_read`/`bmem_write` high. If the k-th strobe arrives at cycle S_k, `pmem_resp` is high at S_BEATS+1.
- With zero-wait memory, the minimum latency is `pmem_resp` at T+BEATS+1.
- Write-back followed by refill: `pmem_resp` for the write at D. The cache raises `pmem_read` at D+1, the adaptor samples it in IDLE, and the read burst starts at D+2.
- All outputs decode from registered state and registers. There is no combinational path from `pmem_*` inputs to `bmem_*` outputs.

## Configuration
- `CLA_LAST_LINE_BUF_EN` defined:
  - Keep a one-entry buffer (valid, aligned tag, line), updated on every completed read burst and every write acceptance.
  - In IDLE, a `pmem_read` whose aligned address matches a valid tag skips RD_BURST and goes directly to DONE, so `pmem_resp` arrives at T+1 with no `bmem` traffic.
  - Valid clears on reset.
- Not defined: every read performs a full burst, and the buffer logic is absent.

## Structure
- Package `cla_pkg`:
  - state enum `cla_state_t`.
  - constants `CLA_LINE_W`, `CLA_BEAT_W`, `CLA_BEATS`, `CLA_OFFSET_W`.
- Sub-module `cla_line_buffer` owns the line register, with beat-indexed write, beat-indexed read and full-line load/read.
- The FSM, counter and optional last-line buffer stay in the top module.

## Test plan
- Read to 0x0000_1234 with zero-wait beats 0x11..,0x22..,0x33..,0x44.. -> `bmem_address`=0x0000_1220; `pmem_rdata`={0x44..,0x33..,0x22..,0x11..} with `pmem_resp` at T+5.
- Write line 0xAAAA.. to 0x100 with one idle cycle between strobes -> four beats in order; `pmem_resp` one cycle after the 4th strobe; `bmem_write` low the following cycle.
- Write-back to 0x200 immediately followed by read of 0x300 (held by the cache as in its controller) -> exactly one write burst then one read burst, two `pmem_resp` pulses, read burst starting at D+2.
- `rst_n` low after the 2nd read beat -> all outputs 0 at once; after release, a fresh read completes normally with counter restarting at beat 0.
- Spurious `bmem_resp` in IDLE, and `pmem_read`+`pmem_write` together -> no state change; write served first, then read.
- `CLA_LAST_LINE_BUF_EN`: read 0x400 twice -> second read gets `pmem_resp` at T+1 with no `bmem_read`. A read of 0x420 still bursts.
